// File: rtl/sync_fifo_ext_if.sv
// Handshake bundle for sync_fifo_ext.
// master drives requests and data, slave returns data and status.
interface sync_fifo_ext_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic             wr_en;
  logic [WIDTH-1:0] din;
  logic             rd_en;
  logic             clr_err;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [LW-1:0]    level;
  logic             overflow;
  logic             underflow;

  modport master (
    output wr_en, din, rd_en, clr_err,
    input  dout, dout_valid, full, empty,
    input  almost_full, almost_empty, level,
    input  overflow, underflow
  );

  modport slave (
    input  wr_en, din, rd_en, clr_err,
    output dout, dout_valid, full, empty,
    output almost_full, almost_empty, level,
    output overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_ext.sv
// Single-clock FIFO with threshold flags, sticky errors
// and a selectable registered or first-word-fall-through read port.
module sync_fifo_ext #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 4,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input logic           clk,
  input logic           rst,
  sync_fifo_ext_if.slave bus
);
  localparam int AW = (DEPTH < 2) ? 1 : $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [LW-1:0] AF_LVL   = LW'(AF_THRESH);
  localparam logic [LW-1:0] AE_LVL   = LW'(AE_THRESH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "sync_fifo_ext: DEPTH must be a power of 2 and >= 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $fatal(1, "sync_fifo_ext: AF_THRESH out of range");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $fatal(1, "sync_fifo_ext: AE_THRESH out of range");
  end
  if (WIDTH < 1) begin : g_bad_width
    $fatal(1, "sync_fifo_ext: WIDTH must be >= 1");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    level_q;
  logic             ovf_q;
  logic             unf_q;
  logic             full;
  logic             empty;
  logic             wr_ok;
  logic             rd_ok;

  assign full  = (level_q == FULL_LVL);
  assign empty = (level_q == '0);
  assign wr_ok = bus.wr_en && !full;
  assign rd_ok = bus.rd_en && !empty;

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (level_q >= AF_LVL);
  assign bus.almost_empty = (level_q <= AE_LVL);
  assign bus.level        = level_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;

  // Storage is never reset; level/pointers make stale words unreachable.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) begin
      mem[wr_ptr] <= bus.din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (wr_ok && !rd_ok) begin
        level_q <= level_q + LW'(1);
      end else if (rd_ok && !wr_ok) begin
        level_q <= level_q - LW'(1);
      end
      // A new error in a clearing cycle keeps the flag set.
      ovf_q <= (bus.wr_en && full) || (ovf_q && !bus.clr_err);
      unf_q <= (bus.rd_en && empty) || (unf_q && !bus.clr_err);
    end
  end

  if (FWFT != 0) begin : g_fwft
    assign bus.dout       = empty ? '0 : mem[rd_ptr];
    assign bus.dout_valid = !empty;
  end else begin : g_reg
    logic [WIDTH-1:0] dout_q;
    logic             dv_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        dout_q <= '0;
        dv_q   <= 1'b0;
      end else begin
        if (rd_ok) begin
          dout_q <= mem[rd_ptr];
        end
        dv_q <= rd_ok;
      end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dv_q;
  end
endmodule
